// File: rtl/microcode_sequencer_if.sv
// -----------------------------------------------------------------------------
// microcode_sequencer_if
// Bundles the signals around the microcode sequencer: the decode-side handshake,
// the command-table lookup and the micro-op stream to the read stage.
//   master : the sequencer (drives dec_accept, table inputs and micro-ops)
//   slave  : the environment (decoder, command table, read stage, flush source)
// -----------------------------------------------------------------------------
interface microcode_sequencer_if;
    // Decode side
    logic        dec_ready;
    logic        dec_is_complex;
    logic [6:0]  dec_cmd;
    logic [3:0]  dec_cmdex;
    logic [87:0] dec_decoder;
    logic        dec_operand_32bit;
    logic        dec_accept;
    // Command table
    logic [6:0]  mc_cmd_next;
    logic [6:0]  mc_cmd_current;
    logic [3:0]  mc_cmdex_current;
    logic [6:0]  mc_cmd;
    logic [5:0]  mc_step;
    logic [3:0]  mc_cmdex_last;
    logic [87:0] mc_decoder;
    logic        mc_operand_32bit;
    // Read stage
    logic        micro_valid;
    logic        micro_busy;
    logic [6:0]  micro_cmd;
    logic [3:0]  micro_cmdex;
    logic        micro_last;
    // Control / status
    logic        exc_flush;
    logic        mc_step_err;
    logic [31:0] perf_mc_instr;
    logic [31:0] perf_mc_steps;

    modport master (
        input  dec_ready, dec_is_complex, dec_cmd, dec_cmdex, dec_decoder, dec_operand_32bit,
        output dec_accept,
        input  mc_cmd_next, mc_cmd_current, mc_cmdex_current,
        output mc_cmd, mc_step, mc_cmdex_last, mc_decoder, mc_operand_32bit,
        output micro_valid, micro_cmd, micro_cmdex, micro_last,
        input  micro_busy, exc_flush,
        output mc_step_err, perf_mc_instr, perf_mc_steps
    );

    modport slave (
        output dec_ready, dec_is_complex, dec_cmd, dec_cmdex, dec_decoder, dec_operand_32bit,
        input  dec_accept,
        output mc_cmd_next, mc_cmd_current, mc_cmdex_current,
        input  mc_cmd, mc_step, mc_cmdex_last, mc_decoder, mc_operand_32bit,
        input  micro_valid, micro_cmd, micro_cmdex, micro_last,
        output micro_busy, exc_flush,
        input  mc_step_err, perf_mc_instr, perf_mc_steps
    );
endinterface

// File: rtl/microcode_sequencer.sv
// -----------------------------------------------------------------------------
// microcode_sequencer
// Accepts decoded instructions; single-step instructions pass straight through
// as one micro-op, multi-step instructions are walked through the microcode
// command table one micro-op per transfer.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - microcode_sequencer_if.master (decode, table, read stage, flush, status)
// Optional feature: define AO486_MC_PERF_EN to build the perf_mc_instr /
// perf_mc_steps counters; otherwise both outputs are tied to 0.
// -----------------------------------------------------------------------------
module microcode_sequencer (
    input  logic                         clk,
    input  logic                         rst,
    microcode_sequencer_if.master        bus
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      r_state, w_state_nxt;

    logic        r_micro_valid, w_micro_valid_nxt;
    logic [6:0]  r_micro_cmd, w_micro_cmd_nxt;
    logic [3:0]  r_micro_cmdex, w_micro_cmdex_nxt;
    logic        r_micro_last, w_micro_last_nxt;
    logic [6:0]  r_mc_cmd, w_mc_cmd_nxt;
    logic [5:0]  r_mc_step, w_mc_step_nxt;
    logic [3:0]  r_mc_cmdex_last, w_mc_cmdex_last_nxt;
    logic [87:0] r_mc_decoder, w_mc_decoder_nxt;
    logic        r_mc_op32, w_mc_op32_nxt;
    logic        r_step_err, w_step_err_nxt;

    logic        w_out_free;
    logic        w_accept;
    logic        w_advance;
    logic        w_seq_end;
    logic        w_step_max;

    assign w_out_free = !r_micro_valid || !bus.micro_busy;
    // rst term keeps dec_accept low while reset is held
    assign w_accept   = (r_state == StIdle) && bus.dec_ready && w_out_free && !bus.exc_flush
                        && !rst;
    assign w_advance  = (r_state == StRun) && w_out_free && !bus.exc_flush;
    assign w_seq_end  = (bus.mc_cmd_next == 7'd0);
    assign w_step_max = (r_mc_step == 6'd63);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (bus.exc_flush) begin
            w_state_nxt = StIdle;
        end else begin
            unique case (r_state)
                StIdle: if (w_accept && bus.dec_is_complex) w_state_nxt = StRun;
                StRun:  if (w_advance && (w_seq_end || w_step_max)) w_state_nxt = StIdle;
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        w_micro_valid_nxt   = r_micro_valid;
        w_micro_cmd_nxt     = r_micro_cmd;
        w_micro_cmdex_nxt   = r_micro_cmdex;
        w_micro_last_nxt    = r_micro_last;
        w_mc_cmd_nxt        = r_mc_cmd;
        w_mc_step_nxt       = r_mc_step;
        w_mc_cmdex_last_nxt = r_mc_cmdex_last;
        w_mc_decoder_nxt    = r_mc_decoder;
        w_mc_op32_nxt       = r_mc_op32;
        w_step_err_nxt      = r_step_err;

        if (bus.exc_flush) begin
            w_micro_valid_nxt = 1'b0;
            w_micro_last_nxt  = 1'b0;
            w_mc_step_nxt     = 6'd0;
            w_mc_cmd_nxt      = 7'd0;
        end else if (r_state == StIdle) begin
            if (w_accept) begin
                w_micro_valid_nxt = 1'b1;
                w_micro_cmd_nxt   = bus.dec_cmd;
                w_micro_cmdex_nxt = bus.dec_cmdex;
                if (bus.dec_is_complex) begin
                    w_micro_last_nxt    = 1'b0;
                    w_mc_cmd_nxt        = bus.dec_cmd;
                    w_mc_cmdex_last_nxt = bus.dec_cmdex;
                    w_mc_step_nxt       = 6'd1;
                    w_mc_decoder_nxt    = bus.dec_decoder;
                    w_mc_op32_nxt       = bus.dec_operand_32bit;
                end else begin
                    w_micro_last_nxt = 1'b1;
                end
            end else if (w_out_free) begin
                w_micro_valid_nxt = 1'b0;
            end
        end else if (w_advance) begin
            w_micro_valid_nxt   = 1'b1;
            w_micro_cmd_nxt     = bus.mc_cmd_current;
            w_micro_cmdex_nxt   = bus.mc_cmdex_current;
            w_mc_cmdex_last_nxt = bus.mc_cmdex_current;
            w_mc_cmd_nxt        = bus.mc_cmd_next;
            w_mc_step_nxt       = r_mc_step + 6'd1;
            // Step 63 with more to come: cut the sequence short instead of wrapping
            if (w_seq_end || w_step_max) begin
                w_micro_last_nxt = 1'b1;
                w_mc_step_nxt    = 6'd0;
            end
            if (w_step_max && !w_seq_end) w_step_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_micro_valid   <= 1'b0;
            r_micro_cmd     <= 7'd0;
            r_micro_cmdex   <= 4'd0;
            r_micro_last    <= 1'b0;
            r_mc_cmd        <= 7'd0;
            r_mc_step       <= 6'd0;
            r_mc_cmdex_last <= 4'd0;
            r_mc_decoder    <= 88'd0;
            r_mc_op32       <= 1'b0;
            r_step_err      <= 1'b0;
        end else begin
            r_micro_valid   <= w_micro_valid_nxt;
            r_micro_cmd     <= w_micro_cmd_nxt;
            r_micro_cmdex   <= w_micro_cmdex_nxt;
            r_micro_last    <= w_micro_last_nxt;
            r_mc_cmd        <= w_mc_cmd_nxt;
            r_mc_step       <= w_mc_step_nxt;
            r_mc_cmdex_last <= w_mc_cmdex_last_nxt;
            r_mc_decoder    <= w_mc_decoder_nxt;
            r_mc_op32       <= w_mc_op32_nxt;
            r_step_err      <= w_step_err_nxt;
        end
    end

`ifdef AO486_MC_PERF_EN
    logic [31:0] r_perf_instr;
    logic [31:0] r_perf_steps;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_instr <= 32'd0;
            r_perf_steps <= 32'd0;
        end else begin
            if (w_accept && bus.dec_is_complex) r_perf_instr <= r_perf_instr + 32'd1;
            if (w_advance)                      r_perf_steps <= r_perf_steps + 32'd1;
        end
    end

    assign bus.perf_mc_instr = r_perf_instr;
    assign bus.perf_mc_steps = r_perf_steps;
`else
    assign bus.perf_mc_instr = 32'd0;
    assign bus.perf_mc_steps = 32'd0;
`endif

    assign bus.dec_accept       = w_accept;
    assign bus.micro_valid      = r_micro_valid;
    assign bus.micro_cmd        = r_micro_cmd;
    assign bus.micro_cmdex      = r_micro_cmdex;
    assign bus.micro_last       = r_micro_last;
    assign bus.mc_cmd           = r_mc_cmd;
    assign bus.mc_step          = r_mc_step;
    assign bus.mc_cmdex_last    = r_mc_cmdex_last;
    assign bus.mc_decoder       = r_mc_decoder;
    assign bus.mc_operand_32bit = r_mc_op32;
    assign bus.mc_step_err      = r_step_err;

endmodule

// File: tb/tb_microcode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_microcode_sequencer
// Drives the sequencer through directed vectors and random traffic. A small
// command-table model answers lookups; the length of each sequence is carried
// in the low 7 bits of the decoder bytes so the table needs no side state.
// -----------------------------------------------------------------------------
module tb_microcode_sequencer;

`ifdef AO486_MC_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic clk;
    logic rst;

    microcode_sequencer_if bus ();

    microcode_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Command table model
    always_comb begin
        bus.mc_cmd_current   = bus.mc_cmd + 7'(bus.mc_step);
        bus.mc_cmdex_current = bus.mc_step[3:0] ^ bus.mc_cmdex_last;
        bus.mc_cmd_next      = (7'(bus.mc_step) < bus.mc_decoder[6:0]) ?
                               7'(bus.mc_step) + 7'd10 : 7'd0;
    end

    typedef struct packed {
        logic [6:0] cmd;
        logic [3:0] cmdex;
        logic       last;
    } op_t;

    typedef struct {
        logic       rdy;
        logic [6:0] cmd;
        logic [3:0] cmdex;
        logic       acc;
        logic       valid;
        logic [6:0] ocmd;
        logic [3:0] ocmdex;
        logic       last;
    } vec_t;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  sb_en   = 1'b0;
    op_t exp_q[$];

    task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected micro-op stream of one instruction, built from the table rules
    task automatic gen_ops(input logic [6:0] c, input logic [3:0] x, input bit cplx,
                           input int len);
        logic [6:0] mcmd;
        logic [3:0] lastx;
        logic [6:0] cur;
        logic [3:0] curx;
        int         leff;
        if (!cplx) begin
            exp_q.push_back('{cmd: c, cmdex: x, last: 1'b1});
            return;
        end
        exp_q.push_back('{cmd: c, cmdex: x, last: 1'b0});
        leff  = (len > 63) ? 63 : len;
        mcmd  = c;
        lastx = x;
        for (int s = 1; s <= leff; s++) begin
            cur  = mcmd + 7'(s);
            curx = 4'(s) ^ lastx;
            exp_q.push_back('{cmd: cur, cmdex: curx, last: (s == leff)});
            lastx = curx;
            mcmd  = (s < len) ? 7'(s + 10) : 7'd0;
        end
    endtask

    // One clock; transfers are scored at the negedge before the edge that takes them
    task automatic tick();
        op_t e;
        @(negedge clk);
        if (sb_en && bus.micro_valid && !bus.micro_busy) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_extra: unexpected op cmd=0x%0h, expected none", bus.micro_cmd);
            end else begin
                e = exp_q.pop_front();
                chk("sb_op", 88'({bus.micro_cmd, bus.micro_cmdex, bus.micro_last}),
                    88'({e.cmd, e.cmdex, e.last}));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        bus.micro_busy = 1'b0;
        bus.dec_ready  = 1'b0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk("drain_empty", 88'(exp_q.size()), 88'd0);
    endtask

    task automatic do_reset();
        bus.dec_ready  = 1'b0;
        bus.micro_busy = 1'b0;
        bus.exc_flush  = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic present(input logic [6:0] c, input logic [3:0] x, input bit cplx,
                           input logic [80:0] hi, input logic [6:0] len);
        bus.dec_ready         = 1'b1;
        bus.dec_is_complex    = cplx;
        bus.dec_cmd           = c;
        bus.dec_cmdex         = x;
        bus.dec_decoder       = {hi, len};
        bus.dec_operand_32bit = cplx;
    endtask

    vec_t vecs[6];
    logic [87:0] dsave;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit         pend;
        logic [6:0] rc;
        logic [3:0] rx;
        bit         rcplx;
        int         rlen;

        vecs[0] = '{1'b1, 7'd5,   4'd2,  1'b1, 1'b1, 7'd5,   4'd2,  1'b1};
        vecs[1] = '{1'b1, 7'd127, 4'd15, 1'b1, 1'b1, 7'd127, 4'd15, 1'b1};
        vecs[2] = '{1'b0, 7'd33,  4'd4,  1'b0, 1'b0, 7'd127, 4'd15, 1'b1};
        vecs[3] = '{1'b1, 7'd0,   4'd0,  1'b1, 1'b1, 7'd0,   4'd0,  1'b1};
        vecs[4] = '{1'b1, 7'd64,  4'd9,  1'b1, 1'b1, 7'd64,  4'd9,  1'b1};
        vecs[5] = '{1'b0, 7'd1,   4'd1,  1'b0, 1'b0, 7'd64,  4'd9,  1'b1};

        // Reset state, with a pending instruction that must not be accepted
        rst = 1'b1;
        bus.micro_busy = 1'b0;
        bus.exc_flush  = 1'b0;
        present(7'd7, 4'd1, 1'b0, 81'd0, 7'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_accept", 88'(bus.dec_accept), 88'd0);
        chk("rst_valid", 88'(bus.micro_valid), 88'd0);
        chk("rst_micro", 88'({bus.micro_cmd, bus.micro_cmdex, bus.micro_last}), 88'd0);
        chk("rst_mc", 88'({bus.mc_cmd, bus.mc_step, bus.mc_cmdex_last}), 88'd0);
        chk("rst_err", 88'(bus.mc_step_err), 88'd0);
        chk("rst_perf", 88'({bus.perf_mc_instr, bus.perf_mc_steps}), 88'd0);
        do_reset();

        // Simple instructions, table-driven
        for (int i = 0; i < 6; i++) begin
            present(vecs[i].cmd, vecs[i].cmdex, 1'b0, 81'd0, 7'd0);
            bus.dec_ready = vecs[i].rdy;
            #1;
            chk("vec_accept", 88'(bus.dec_accept), 88'(vecs[i].acc));
            tick();
            chk("vec_valid", 88'(bus.micro_valid), 88'(vecs[i].valid));
            chk("vec_op", 88'({bus.micro_cmd, bus.micro_cmdex, bus.micro_last}),
                88'({vecs[i].ocmd, vecs[i].ocmdex, vecs[i].last}));
            chk("vec_step", 88'(bus.mc_step), 88'd0);
        end
        bus.dec_ready = 1'b0;
        tick();

        // Complex, 3 table steps, no stall
        sb_en = 1'b1;
        present(7'd20, 4'd3, 1'b1, 81'h1_2345_6789_abcd_ef01, 7'd3);
        #1;
        chk("c3_accept", 88'(bus.dec_accept), 88'd1);
        gen_ops(7'd20, 4'd3, 1'b1, 3);
        tick();
        bus.dec_ready = 1'b0;
        chk("c3_first", 88'({bus.micro_valid, bus.micro_cmd, bus.micro_last}),
            88'({1'b1, 7'd20, 1'b0}));
        chk("c3_table_in", 88'({bus.mc_cmd, bus.mc_cmdex_last, bus.mc_operand_32bit}),
            88'({7'd20, 4'd3, 1'b1}));
        chk("c3_decoder", bus.mc_decoder, {81'h1_2345_6789_abcd_ef01, 7'd3});
        chk("c3_step1", 88'(bus.mc_step), 88'd1);
        tick();
        chk("c3_step2", 88'(bus.mc_step), 88'd2);
        chk("c3_last2", 88'(bus.micro_last), 88'd0);
        tick();
        chk("c3_step3", 88'(bus.mc_step), 88'd3);
        tick();
        chk("c3_step0", 88'(bus.mc_step), 88'd0);
        chk("c3_last", 88'({bus.micro_valid, bus.micro_last}), 88'b11);
        tick();
        chk("c3_idle", 88'(bus.micro_valid), 88'd0);
        chk("c3_perf_instr", 88'(bus.perf_mc_instr), PerfEn ? 88'd1 : 88'd0);
        chk("c3_perf_steps", 88'(bus.perf_mc_steps), PerfEn ? 88'd3 : 88'd0);
        chk("c3_empty", 88'(exp_q.size()), 88'd0);

        // Stall mid-sequence
        present(7'd30, 4'd5, 1'b1, 81'd77, 7'd4);
        #1;
        chk("st_accept", 88'(bus.dec_accept), 88'd1);
        gen_ops(7'd30, 4'd5, 1'b1, 4);
        tick();
        bus.dec_ready = 1'b0;
        tick();
        bus.micro_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_op", 88'({bus.micro_valid, bus.micro_cmd, bus.micro_cmdex}),
                88'({1'b1, exp_q[0].cmd, exp_q[0].cmdex}));
            chk("st_table", 88'({bus.mc_step, bus.mc_cmd}), 88'({6'd2, 7'd11}));
        end
        drain(20);
        chk("st_step_end", 88'(bus.mc_step), 88'd0);

        // Flush at step 2, together with a stall and a waiting instruction
        present(7'd40, 4'd6, 1'b1, 81'h5a5a, 7'd5);
        #1;
        gen_ops(7'd40, 4'd6, 1'b1, 5);
        dsave = bus.dec_decoder;
        tick();
        bus.dec_ready = 1'b0;
        tick();
        chk("fl_step2", 88'(bus.mc_step), 88'd2);
        sb_en = 1'b0;
        exp_q.delete();
        bus.exc_flush  = 1'b1;
        bus.micro_busy = 1'b1;
        present(7'd50, 4'd7, 1'b0, 81'd0, 7'd0);
        #1;
        chk("fl_no_accept", 88'(bus.dec_accept), 88'd0);
        tick();
        bus.exc_flush  = 1'b0;
        bus.micro_busy = 1'b0;
        chk("fl_out", 88'({bus.micro_valid, bus.micro_last}), 88'd0);
        chk("fl_mc", 88'({bus.mc_step, bus.mc_cmd}), 88'd0);
        chk("fl_decoder", bus.mc_decoder, dsave);
        #1;
        chk("fl_reaccept", 88'(bus.dec_accept), 88'd1);
        sb_en = 1'b1;
        gen_ops(7'd50, 4'd7, 1'b0, 0);
        tick();
        bus.dec_ready = 1'b0;
        chk("fl_new_op", 88'({bus.micro_valid, bus.micro_cmd, bus.micro_last}),
            88'({1'b1, 7'd50, 1'b1}));
        drain(10);

        // Step overflow: table never ends the sequence
        do_reset();
        present(7'd60, 4'd0, 1'b1, 81'h3, 7'd127);
        #1;
        chk("ov_accept", 88'(bus.dec_accept), 88'd1);
        gen_ops(7'd60, 4'd0, 1'b1, 127);
        tick();
        bus.dec_ready = 1'b0;
        chk("ov_err_early", 88'(bus.mc_step_err), 88'd0);
        drain(200);
        chk("ov_err", 88'(bus.mc_step_err), 88'd1);
        chk("ov_end", 88'({bus.mc_step, bus.micro_last}), 88'({6'd0, 1'b1}));
        chk("ov_perf_steps", 88'(bus.perf_mc_steps), PerfEn ? 88'd63 : 88'd0);
        present(7'd9, 4'd9, 1'b0, 81'd0, 7'd0);
        #1;
        chk("ov_idle_accept", 88'(bus.dec_accept), 88'd1);
        gen_ops(7'd9, 4'd9, 1'b0, 0);
        tick();
        drain(10);
        chk("ov_err_sticky", 88'(bus.mc_step_err), 88'd1);

        // Asynchronous reset mid-RUN
        sb_en = 1'b0;
        present(7'd70, 4'd2, 1'b1, 81'd0, 7'd6);
        tick();
        tick();
        chk("ar_running", 88'(bus.mc_step), 88'd2);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_accept", 88'(bus.dec_accept), 88'd0);
        chk("ar_out", 88'({bus.micro_valid, bus.micro_cmd, bus.micro_cmdex, bus.micro_last}),
            88'd0);
        chk("ar_mc", 88'({bus.mc_step, bus.mc_cmd, bus.mc_step_err}), 88'd0);
        chk("ar_perf", 88'({bus.perf_mc_instr, bus.perf_mc_steps}), 88'd0);
        do_reset();

        // Random traffic against the stream model
        sb_en = 1'b1;
        pend  = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!pend && $urandom_range(0, 2) == 0) begin
                rc    = 7'($urandom);
                rx    = 4'($urandom);
                rcplx = 1'($urandom);
                rlen  = $urandom_range(1, 6);
                present(rc, rx, rcplx, 81'($urandom), 7'(rlen));
                pend = 1'b1;
            end
            bus.micro_busy = ($urandom_range(0, 3) == 0);
            #1;
            if (pend && bus.dec_accept) begin
                gen_ops(rc, rx, rcplx, rlen);
                pend = 1'b0;
            end
            tick();
            if (!pend) bus.dec_ready = 1'b0;
        end
        drain(100);
        chk("rnd_err", 88'(bus.mc_step_err), 88'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/microcode_sequencer.md
# microcode_sequencer

Sequencer that drives the microcode command table and feeds the read stage. It accepts decoded instructions from the decode/microcode boundary. Single-step instructions pass straight through. Multi-step instructions are walked one micro-op per transfer: the sequencer presents `mc_cmd`, `mc_step`, `mc_cmdex_last` and `mc_decoder` to the command table, and registers the table's `mc_cmd_current`/`mc_cmdex_current` into the outgoing micro-op.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  — clock; single clock domain.
- `rst`  in  1  — reset, asynchronous, active-high.
- `dec_ready`  in  1  — decoded instruction valid.
- `dec_is_complex`  in  1  — instruction needs microcode steps.
- `dec_cmd`  in  7  — first command.
- `dec_cmdex`  in  4  — first command extension.
- `dec_decoder`  in  88  — decoder bytes.
- `dec_operand_32bit`  in  1  — operand size.
- `dec_accept`  out  1  — instruction consumed this cycle (combinational).
- `mc_cmd_next`  in  7  — from table; 7'd0 means the sequence ends after the current step.
- `mc_cmd_current`  in  7  — from table.
- `mc_cmdex_current`  in  4  — from table.
- `mc_cmd`  out  7  — to table.
- `mc_step`  out  6  — to table.
- `mc_cmdex_last`  out  4  — to table.
- `mc_decoder`  out  88  — to table.
- `mc_operand_32bit`  out  1  — to table.
- `micro_valid`  out  1  — micro-op valid to read stage.
- `micro_busy`  in  1  — read stage stall.
- `micro_cmd`  out  7  — micro-op command.
- `micro_cmdex`  out  4  — micro-op command extension.
- `micro_last`  out  1  — final micro-op of the instruction.
- `exc_flush`  in  1  — synchronous pipeline flush.
- `mc_step_err`  out  1  — sticky step-overflow flag.
- `perf_mc_instr`  out  32  — complex instruction count (macro-gated).
- `perf_mc_steps`  out  32  — table step count (macro-gated).

## Operation
- States: IDLE and RUN.
- `out_free = !micro_valid | !micro_busy`. A transfer occurs on `micro_valid & !micro_busy`.
- `dec_accept = (state==IDLE) & dec_ready & out_free & !exc_flush`.
- On accept:
  - `micro_valid<=1`, `micro_cmd<=dec_cmd`, `micro_cmdex<=dec_cmdex`.
  - If `!dec_is_complex`: `micro_last<=1`, stay in IDLE.
  - If `dec_is_complex`: `micro_last<=0`, `mc_cmd<=dec_cmd`, `mc_cmdex_last<=dec_cmdex`, `mc_step<=1`, latch `mc_decoder` and `mc_operand_32bit`, go to RUN.
- IDLE, `out_free`, no accept: `micro_valid<=0`.
- RUN with `out_free`:
  - `micro_valid<=1`, `micro_cmd<=mc_cmd_current`, `micro_cmdex<=mc_cmdex_current`.
  - `mc_cmdex_last<=mc_cmdex_current`, `mc_cmd<=mc_cmd_next`, `mc_step<=mc_step+1`.
  - If `mc_cmd_next==0`: `micro_last<=1`, `mc_step<=0`, go to IDLE.
- RUN with `!out_free`: all registers hold. The table inputs are stable, so the table outputs are stable.
- Step overflow: in RUN with `mc_step==63`, `out_free` and `mc_cmd_next!=0`:
  - Force the end of the sequence: `micro_last<=1`, go to IDLE, `mc_step<=0`.
  - Set `mc_step_err`. It stays set until `rst`; no wrap to 0 mid-sequence.
- `exc_flush` has priority over everything. Next cycle: `micro_valid=0`, `micro_last=0`, state IDLE, `mc_step=0`, `mc_cmd=0`. `mc_decoder` holds its value. No accept in the flush cycle.

## Timing
- Reset values: every output 0, state IDLE. `dec_accept` evaluates to 0 under reset.
- Simple instruction: accept at cycle N, `micro_valid` at N+1.
- Complex instruction with k table steps:
  - First micro-op (`dec_cmd`) at N+1.
  - Table steps at N+2..N+1+k with no stall.
  - Next accept possible at N+1+k, concurrent with the last transfer.
- Throughput: one micro-op per cycle while `micro_busy=0`.
- A stall while `micro_valid=1` freezes every output.
- `exc_flush` and `micro_busy` high together: flush wins.

## Configuration
- `AO486_MC_PERF_EN` defined:
  - `perf_mc_instr` increments on each complex accept.
  - `perf_mc_steps` increments on each RUN-state advance.
  - Both are 32-bit, wrap at 2^32, reset to 0, and are unaffected by flush.
- Not defined: both outputs tied to 0 and no counter registers are built.

## Test plan
- Simple: `dec_ready=1`, `dec_is_complex=0`, `dec_cmd=7'd5`, `dec_cmdex=4'd2` → `dec_accept=1`; next cycle `micro_valid=1`, `micro_cmd=5`, `micro_cmdex=2`, `micro_last=1`, `mc_step=0`.
- Complex, 3 table steps, no stall: table model returns `mc_cmd_next` = 9, 9, 0 → micro-ops on 4 consecutive cycles; `mc_step` 1, 2, 3, then 0; `micro_last` set only on the 4th; `perf_mc_instr=1`, `perf_mc_steps=3` with the macro defined.
- Stall: `micro_busy=1` for 3 cycles mid-sequence → `micro_cmd`, `micro_cmdex`, `mc_step` and `mc_cmd` unchanged throughout; sequence resumes with no micro-op lost or duplicated.
- Flush: `exc_flush` pulsed at `mc_step=2` → next cycle `micro_valid=0`, state IDLE, `mc_step=0`; a new instruction is accepted the following cycle.
- Overflow: table always returns `mc_cmd_next=7'd9` → after `mc_step` reaches 63, `micro_last=1`, `mc_step_err=1` (sticky), state IDLE.
- Reset: assert `rst` mid-RUN asynchronously → all outputs 0 immediately, `perf_mc_instr=0`, `perf_mc_steps=0`.
